// File: rtl/defines_pkg.sv
// Shared type definitions for the dataflow buffer blocks.
package defines_pkg;
    typedef enum logic {BANK0, BANK1} bank_t;
endpackage

// File: rtl/memory.sv
// Simple dual-port storage: synchronous write, combinational read.
module memory #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 32,
    parameter int AW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [SIZE];

    // Contents are don't-care after reset; only block writes while it is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong buffer: producer fills one bank while the consumer drains
// the other; controller toggle pulses hand banks across.
module pingpong_buffer
    import defines_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CSIZE      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_toggle,
    input  logic                  rd_toggle,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_avail,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  wr_ovf,
    output logic                  rd_unf,
    output logic                  tog_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CSIZE-1:0] DEPTH_C = CSIZE'(DEPTH);

    bank_t                       wb_q, wb_d, rb_q, rb_d;
    logic [CSIZE-1:0]            wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [1:0]                  ready_q, ready_d, ready_rel;
    logic [1:0][CSIZE-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d, mem_rd_data;
    logic                        rd_valid_q, rd_valid_d;
    logic                        wr_ovf_q, wr_ovf_d, rd_unf_q, rd_unf_d, tog_err_q, tog_err_d;
    logic                        wr_acc, rd_acc, wr_tog_acc, rd_tog_acc;

    memory #(.WIDTH(DATA_WIDTH), .SIZE(2 * DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr ({wb_q, wr_cnt_q[AW-1:0]}),
        .wr_data (wr_data),
        .rd_addr ({rb_q, rd_cnt_q[AW-1:0]}),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        wr_acc     = wr_valid && (wr_cnt_q < DEPTH_C);
        rd_acc     = rd_en && ready_q[rb_q] && (rd_cnt_q < count_q[rb_q]);
        rd_tog_acc = rd_toggle && ready_q[rb_q];
        // Release is applied before the write toggle looks at its target bank,
        // so a write toggle can claim the bank freed in the same cycle.
        ready_rel = ready_q;
        if (rd_tog_acc) ready_rel[rb_q] = 1'b0;
        wr_tog_acc = wr_toggle && !ready_rel[~wb_q];

        wb_d       = wb_q;
        rb_d       = rb_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        ready_d    = ready_rel;
        count_d    = count_q;

        if (wr_acc) wr_cnt_d = wr_cnt_q + CSIZE'(1);
        if (wr_tog_acc) begin
            ready_d[wb_q] = 1'b1;
            count_d[wb_q] = wr_cnt_q + CSIZE'(wr_acc);
            wb_d          = bank_t'(~wb_q);
            wr_cnt_d      = '0;
        end

        if (rd_acc) rd_cnt_d = rd_cnt_q + CSIZE'(1);
        if (rd_tog_acc) begin
            rb_d     = bank_t'(~rb_q);
            rd_cnt_d = '0;
        end

        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem_rd_data : rd_data_q;
        wr_ovf_d   = wr_valid && !wr_acc;
        rd_unf_d   = rd_en && !rd_acc;
        tog_err_d  = (wr_toggle && !wr_tog_acc) || (rd_toggle && !rd_tog_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q       <= BANK0;
            rb_q       <= BANK0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            ready_q    <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ovf_q   <= 1'b0;
            rd_unf_q   <= 1'b0;
            tog_err_q  <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ovf_q   <= wr_ovf_d;
            rd_unf_q   <= rd_unf_d;
            tog_err_q  <= tog_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_avail = ready_q[rb_q];
    assign wr_bank  = wb_q;
    assign rd_bank  = rb_q;
    assign wr_ovf   = wr_ovf_q;
    assign rd_unf   = rd_unf_q;
    assign tog_err  = tog_err_q;
endmodule

// File: tb/tb_pingpong_buffer.sv
module tb_pingpong_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_toggle = 1'b0, rd_toggle = 1'b0, wr_valid = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, rd_avail, wr_bank, rd_bank, wr_ovf, rd_unf, tog_err;
  int         total = 0;
  int         bad = 0;

  pingpong_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_toggle(wr_toggle), .rd_toggle(rd_toggle),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_avail(rd_avail), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .wr_ovf(wr_ovf), .rd_unf(rd_unf), .tog_err(tog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic cyc(input logic wv, input logic [7:0] wd, input logic wt,
                     input logic re, input logic rt, input logic r = 1'b0);
    wr_valid = wv; wr_data = wd; wr_toggle = wt; rd_en = re; rd_toggle = rt; rst = r;
    @(posedge clk); #1;
    wr_valid = 0; wr_toggle = 0; rd_en = 0; rd_toggle = 0; rst = 0;
  endtask

  task automatic wr(input logic [7:0] d); cyc(1, d, 0, 0, 0); endtask
  task automatic rd(input logic [7:0] d, input string tag);
    cyc(0, 0, 0, 1, 0);
    chk({tag, "_vld"}, rd_valid === 1'b1);
    chk({tag, "_dat"}, rd_data === d);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_data", rd_data === 8'h00);
    chk("rst_vld", rd_valid === 1'b0);
    chk("rst_avail", rd_avail === 1'b0);
    chk("rst_wb", wr_bank === 1'b0);
    chk("rst_rb", rd_bank === 1'b0);
    chk("rst_errs", {wr_ovf, rd_unf, tog_err} === 3'b000);

    wr(8'h11); wr(8'h12); wr(8'h13); wr(8'h14);
    chk("b_avail_pre", rd_avail === 1'b0);
    cyc(0, 0, 1, 0, 0);
    chk("b_wb", wr_bank === 1'b1);
    chk("b_avail", rd_avail === 1'b1);
    chk("b_rb", rd_bank === 1'b0);
    rd(8'h11, "b_r0"); rd(8'h12, "b_r1"); rd(8'h13, "b_r2"); rd(8'h14, "b_r3");
    cyc(0, 0, 0, 1, 0);
    chk("b_unf", rd_unf === 1'b1);
    chk("b_unf_vld", rd_valid === 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("b_unf_pulse", rd_unf === 1'b0);
    chk("b_hold", rd_data === 8'h14);
    cyc(0, 0, 0, 0, 1);
    chk("b_rtog_err", tog_err === 1'b0);
    chk("b_rtog_rb", rd_bank === 1'b1);
    chk("b_rtog_avail", rd_avail === 1'b0);

    wr(8'h21); wr(8'h22); wr(8'h23); wr(8'h24);
    chk("o_no_ovf", wr_ovf === 1'b0);
    wr(8'h25);
    chk("o_ovf", wr_ovf === 1'b1);
    cyc(0, 0, 1, 0, 0);
    chk("o_ovf_pulse", wr_ovf === 1'b0);
    chk("o_wb", wr_bank === 1'b0);
    chk("o_avail", rd_avail === 1'b1);
    rd(8'h21, "o_r0"); rd(8'h22, "o_r1"); rd(8'h23, "o_r2"); rd(8'h24, "o_r3");
    cyc(0, 0, 0, 1, 0);
    chk("o_unf", rd_unf === 1'b1);
    cyc(0, 0, 0, 0, 1);
    chk("o_rb", rd_bank === 1'b0);

    wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34);
    cyc(0, 0, 1, 0, 0);
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
    cyc(0, 0, 1, 0, 0);
    chk("t_err", tog_err === 1'b1);
    chk("t_wb", wr_bank === 1'b1);
    wr(8'h45);
    chk("t_ovf", wr_ovf === 1'b1);
    chk("t_err_pulse", tog_err === 1'b0);
    rd(8'h31, "t_r0");

    cyc(0, 0, 0, 0, 0, 1);
    chk("s_rst_wb", wr_bank === 1'b0);
    chk("s_rst_avail", rd_avail === 1'b0);
    wr(8'h51); wr(8'h52); wr(8'h53);
    cyc(0, 0, 1, 0, 0);
    wr(8'h61); wr(8'h62);
    cyc(0, 0, 1, 0, 1);
    chk("s_err", tog_err === 1'b0);
    chk("s_rb", rd_bank === 1'b1);
    chk("s_wb", wr_bank === 1'b0);
    chk("s_avail", rd_avail === 1'b1);
    rd(8'h61, "s_r0"); rd(8'h62, "s_r1");
    cyc(0, 0, 0, 1, 0);
    chk("s_unf", rd_unf === 1'b1);

    cyc(0, 0, 0, 0, 1);
    chk("w_rb", rd_bank === 1'b0);
    wr(8'h71); wr(8'h72);
    cyc(1, 8'h73, 1, 0, 0);
    chk("w_wb", wr_bank === 1'b1);
    chk("w_avail", rd_avail === 1'b1);
    rd(8'h71, "w_r0"); rd(8'h72, "w_r1"); rd(8'h73, "w_r2");
    cyc(0, 0, 0, 1, 0);
    chk("w_unf", rd_unf === 1'b1);
    cyc(0, 0, 0, 0, 1);
    chk("w_rtog_ok", tog_err === 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("w_rtog_err", tog_err === 1'b1);
    chk("w_rtog_rb", rd_bank === 1'b1);

    wr(8'h81); wr(8'h82); wr(8'h83); wr(8'h84);
    cyc(0, 0, 1, 0, 0);
    chk("r_avail", rd_avail === 1'b1);
    rd(8'h81, "r_r0"); rd(8'h82, "r_r1");
    cyc(0, 0, 0, 0, 0, 1);
    chk("r_vld", rd_valid === 1'b0);
    chk("r_avail0", rd_avail === 1'b0);
    chk("r_banks", {wr_bank, rd_bank} === 2'b00);
    chk("r_data", rd_data === 8'h00);
    cyc(0, 0, 0, 1, 0);
    chk("r_unf", rd_unf === 1'b1);
    chk("r_unf_vld", rd_valid === 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
